// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped interrupt controller feeding the core's INT inputs
//
// Synchronises NUM_SRC asynchronous lines, applies per-source polarity,
// edge/level mode and masking, and exposes the registers on the data bus.
// Optional build macro IRQ_CTRL_COUNT_EN adds per-source 8-bit saturating
// counters of PEND 0->1 transitions at offsets 0x20+4*i.
//
// Ports:
//   clk     - system clock, rising edge
//   rst     - synchronous active-low reset
//   irq_in  - asynchronous interrupt lines
//   we      - bus write strobe
//   addr    - bus byte address
//   wd      - bus write data
//   rd      - bus read data (combinational, 0 when hit=0)
//   hit     - address falls inside the 64-byte register window
//   int_out - PEND & MASK towards the core
module irq_ctrl #(
    parameter int          NUM_SRC   = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0800
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic               we,
    input  logic [31:0]        addr,
    input  logic [31:0]        wd,
    output logic [31:0]        rd,
    output logic               hit,
    output logic [NUM_SRC-1:0] int_out
);
    localparam int PAD = 32 - NUM_SRC;

    logic [NUM_SRC-1:0] r_ff1, r_ff2, r_prev, r_pend, r_mask, r_mode, r_pol;
    logic [NUM_SRC-1:0] w_s, w_set, w_clr, w_force, w_wdat, w_act;
    logic [3:0]         w_off;
    logic               w_wr;
    logic [2:0]         w_idx;
    logic [7:0]         w_cnt_rd;
    logic               w_unused;

    assign hit     = addr[31:6] == BASE_ADDR[31:6];
    assign w_off   = addr[5:2];
    assign w_wr    = hit & we;
    assign w_wdat  = wd[NUM_SRC-1:0];
    assign w_s     = r_ff2 ^ r_pol;
    assign w_force = (w_wr && w_off == 4'h6) ? w_wdat : '0;
    assign w_clr   = (w_wr && w_off == 4'h1) ? w_wdat : '0;
    // level sources set whenever active; edge sources only when prev was idle
    assign w_set   = (w_s & ~(r_mode & r_prev)) | w_force;
    assign w_act   = r_pend & r_mask;
    assign int_out = w_act;
    assign w_unused = &{1'b0, addr[1:0], wd[31:NUM_SRC]};

    // scanning downwards leaves the lowest active index in w_idx
    always_comb begin
        w_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--)
            if (w_act[i]) w_idx = 3'(i);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ff1  <= '0;
            r_ff2  <= '0;
            r_prev <= '0;
            r_pend <= '0;
            r_mask <= '0;
            r_mode <= '0;
            r_pol  <= '0;
        end else begin
            r_ff1  <= irq_in;
            r_ff2  <= r_ff1;
            // a polarity change re-seeds prev so it cannot look like an edge
            r_prev <= (w_wr && w_off == 4'h4) ? (r_ff2 ^ w_wdat) : w_s;
            r_pend <= (r_pend & ~w_clr) | w_set;
            if (w_wr && w_off == 4'h2) r_mask <= w_wdat;
            if (w_wr && w_off == 4'h3) r_mode <= w_wdat;
            if (w_wr && w_off == 4'h4) r_pol  <= w_wdat;
        end
    end

`ifdef IRQ_CTRL_COUNT_EN
    logic [7:0] r_cnt [NUM_SRC];

    // clear beats increment; increment only on a PEND 0->1 transition
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!rst || (w_wr && w_off == 4'(8 + i)))
                r_cnt[i] <= '0;
            else if (w_set[i] && !r_pend[i] && r_cnt[i] != 8'hFF)
                r_cnt[i] <= r_cnt[i] + 8'd1;
        end
    end

    always_comb begin
        w_cnt_rd = '0;
        for (int i = 0; i < NUM_SRC; i++)
            if (w_off == 4'(8 + i)) w_cnt_rd = r_cnt[i];
    end
`else
    assign w_cnt_rd = '0;
`endif

    always_comb begin
        rd = '0;
        if (hit) begin
            case (w_off)
                4'h0:    rd = {{PAD{1'b0}}, w_s};
                4'h1:    rd = {{PAD{1'b0}}, r_pend};
                4'h2:    rd = {{PAD{1'b0}}, r_mask};
                4'h3:    rd = {{PAD{1'b0}}, r_mode};
                4'h4:    rd = {{PAD{1'b0}}, r_pol};
                4'h5:    rd = {|w_act, 28'd0, w_idx};
                default: rd = {24'd0, w_cnt_rd};
            endcase
        end
    end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: randomized and directed self-checking bench for irq_ctrl
module tb_irq_ctrl;
    localparam logic [31:0] BASE = 32'h0000_0800;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  irq_in = '0;
    logic        we = 1'b0;
    logic [31:0] addr = BASE;
    logic [31:0] wd = '0;
    logic [31:0] rd;
    logic        hit;
    logic [3:0]  int_out;
    int          n_chk = 0;
    int          n_fail = 0;

    irq_ctrl dut (
        .clk(clk), .rst(rst), .irq_in(irq_in), .we(we), .addr(addr),
        .wd(wd), .rd(rd), .hit(hit), .int_out(int_out)
    );

    always #5 clk = ~clk;

    // Behavioural model: a line becomes visible two edges after it is
    // sampled; m_last_s is the polarity-adjusted value seen last cycle.
    logic [3:0] m_h1 = '0, m_h2 = '0, m_last_s = '0;
    logic [3:0] m_pend = '0, m_mask = '0, m_mode = '0, m_pol = '0;
    int         m_cnt [4] = '{0, 0, 0, 0};

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        logic [3:0]  act;
        logic [31:0] r;
        r = '0;
        act = m_pend & m_mask;
        if ((a >> 6) != (BASE >> 6)) return '0;
        case (a[5:2])
            4'd0: r = {28'd0, m_h2 ^ m_pol};
            4'd1: r = {28'd0, m_pend};
            4'd2: r = {28'd0, m_mask};
            4'd3: r = {28'd0, m_mode};
            4'd4: r = {28'd0, m_pol};
            4'd5: if (act != 0) begin
                r[31] = 1'b1;
                for (int i = 3; i >= 0; i--) if (act[i]) r[2:0] = 3'(i);
            end
`ifdef IRQ_CTRL_COUNT_EN
            4'd8, 4'd9, 4'd10, 4'd11: r = 32'(m_cnt[a[3:2]]);
`endif
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic tick();
        logic [3:0] s, set, clr, v, off;
        logic       wr;
        s   = m_h2 ^ m_pol;
        wr  = we && ((addr >> 6) == (BASE >> 6));
        off = addr[5:2];
        v   = wd[3:0];
        set = '0;
        for (int i = 0; i < 4; i++) begin
            if (m_mode[i] ? (s[i] && !m_last_s[i]) : s[i]) set[i] = 1'b1;
            if (wr && off == 4'd6 && v[i]) set[i] = 1'b1;
        end
        clr = (wr && off == 4'd1) ? v : 4'd0;
        @(posedge clk);
        if (!rst) begin
            m_h1 = 0; m_h2 = 0; m_last_s = 0; m_pend = 0;
            m_mask = 0; m_mode = 0; m_pol = 0;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (wr && off == 4'(8 + i)) m_cnt[i] = 0;
                else if (set[i] && !m_pend[i] && m_cnt[i] < 255) m_cnt[i]++;
            end
            m_pend   = (m_pend & ~clr) | set;
            m_last_s = (wr && off == 4'd4) ? (m_h2 ^ v) : s;
            if (wr && off == 4'd2) m_mask = v;
            if (wr && off == 4'd3) m_mode = v;
            if (wr && off == 4'd4) m_pol = v;
            m_h2 = m_h1;
            m_h1 = irq_in;
        end
        #1;
    endtask

    task automatic wr(input logic [7:0] o, input logic [31:0] d);
        we = 1'b1; addr = BASE + 32'(o); wd = d;
        tick();
        we = 1'b0;
    endtask

    task automatic peek(input logic [7:0] o);
        we = 1'b0; addr = BASE + 32'(o);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; irq_in = 4'hF;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_chk++; if (int_out !== 4'h0) begin n_fail++; $display("FAIL reset_int_out: got %h expected 0", int_out); end
            peek(8'h04);
            n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_pend: got %h expected 0", rd); end
            peek(8'h14);
            n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_claim: got %h expected 0", rd); end
        end
        rst = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            peek(8'h04);
            n_chk++; if (rd !== ((k == 3) ? 32'hF : 32'h0)) begin n_fail++; $display("FAIL release_pend_%0d: got %h expected %h", k, rd, (k == 3) ? 32'hF : 32'h0); end
            n_chk++; if (int_out !== 4'h0) begin n_fail++; $display("FAIL release_int_out_%0d: got %h expected 0", k, int_out); end
        end
    endtask

    task automatic test_edge();
        irq_in = 4'h0;
        repeat (3) tick();
        wr(8'h0C, 32'hF); wr(8'h08, 32'h4); wr(8'h04, 32'hF);
        peek(8'h04);
        n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL edge_idle_pend: got %h expected 0", rd); end
        irq_in = 4'h4; tick();
        irq_in = 4'h0; tick();
        n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL edge_early_pend: got %h expected 0", rd); end
        tick();
        n_chk++; if (rd !== 32'h4) begin n_fail++; $display("FAIL edge_pend: got %h expected 4", rd); end
        n_chk++; if (int_out !== 4'h4) begin n_fail++; $display("FAIL edge_int_out: got %h expected 4", int_out); end
        peek(8'h14);
        n_chk++; if (rd !== 32'h8000_0002) begin n_fail++; $display("FAIL edge_claim: got %h expected 80000002", rd); end
        wr(8'h04, 32'h4);
        peek(8'h04);
        n_chk++; if (rd !== 32'h0 || int_out !== 4'h0) begin n_fail++; $display("FAIL edge_w1c: got pend %h int %h expected 0 0", rd, int_out); end
        repeat (4) tick();
        n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL edge_retrigger: got %h expected 0", rd); end
    endtask

    task automatic test_level();
        wr(8'h0C, 32'h0); wr(8'h08, 32'h1);
        irq_in = 4'h1;
        repeat (3) tick();
        peek(8'h04);
        n_chk++; if (rd !== 32'h1 || int_out !== 4'h1) begin n_fail++; $display("FAIL level_set: got pend %h int %h expected 1 1", rd, int_out); end
        wr(8'h04, 32'h1);
        peek(8'h04);
        n_chk++; if (rd !== 32'h1) begin n_fail++; $display("FAIL level_set_wins: got %h expected 1", rd); end
        irq_in = 4'h0;
        repeat (3) tick();
        wr(8'h04, 32'h1);
        peek(8'h04);
        n_chk++; if (rd !== 32'h0 || int_out !== 4'h0) begin n_fail++; $display("FAIL level_clear: got pend %h int %h expected 0 0", rd, int_out); end
    endtask

    task automatic test_polarity();
        irq_in = 4'h2;
        repeat (3) tick();
        wr(8'h0C, 32'h2); wr(8'h10, 32'h2); wr(8'h04, 32'hF);
        peek(8'h04);
        n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL pol_idle: got %h expected 0", rd); end
        irq_in = 4'h0;
        tick(); tick();
        n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL pol_early: got %h expected 0", rd); end
        tick();
        n_chk++; if (rd !== 32'h2) begin n_fail++; $display("FAIL pol_fall_pend: got %h expected 2", rd); end
        n_chk++; if (int_out !== 4'h0) begin n_fail++; $display("FAIL pol_masked_int: got %h expected 0", int_out); end
        wr(8'h08, 32'h2);
        n_chk++; if (int_out !== 4'h2) begin n_fail++; $display("FAIL pol_unmask_int: got %h expected 2", int_out); end
        wr(8'h04, 32'h2);
        irq_in = 4'h2;
        repeat (3) tick();
        peek(8'h04);
        n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL pol_inactive_rise: got %h expected 0", rd); end
        wr(8'h10, 32'h0);
        repeat (3) tick();
        peek(8'h04);
        n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL pol_switch_spurious: got %h expected 0", rd); end
    endtask

    task automatic test_force();
        wr(8'h08, 32'hF); wr(8'h18, 32'hA);
        peek(8'h14);
        n_chk++; if (rd !== 32'h8000_0001) begin n_fail++; $display("FAIL force_claim: got %h expected 80000001", rd); end
        peek(8'h18);
        n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL force_read: got %h expected 0", rd); end
        wr(8'h04, 32'h2);
        peek(8'h14);
        n_chk++; if (rd !== 32'h8000_0003) begin n_fail++; $display("FAIL force_claim_next: got %h expected 80000003", rd); end
        wr(8'h04, 32'hF);
        peek(8'h14);
        n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL claim_empty: got %h expected 0", rd); end
    endtask

    task automatic test_decode();
        we = 1'b1; addr = BASE + 32'h48; wd = 32'h0;
        #1;
        n_chk++; if (hit !== 1'b0 || rd !== 32'h0) begin n_fail++; $display("FAIL decode_miss: got hit %b rd %h expected 0 0", hit, rd); end
        tick();
        we = 1'b0;
        peek(8'h08);
        n_chk++; if (rd !== 32'hF || hit !== 1'b1) begin n_fail++; $display("FAIL decode_mask_kept: got %h hit %b expected f 1", rd, hit); end
        wr(8'h1C, 32'hFFFF_FFFF);
        n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL decode_unmapped: got %h expected 0", rd); end
`ifndef IRQ_CTRL_COUNT_EN
        wr(8'h20, 32'hFFFF_FFFF);
        n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL decode_cnt_off: got %h expected 0", rd); end
`endif
    endtask

`ifdef IRQ_CTRL_COUNT_EN
    task automatic test_count();
        irq_in = 4'h0;
        wr(8'h0C, 32'h1); wr(8'h04, 32'hF); wr(8'h20, 32'h0);
        for (int k = 0; k < 300; k++) begin
            irq_in = 4'h1; tick();
            irq_in = 4'h0; tick();
            tick();
            wr(8'h04, 32'h1);
        end
        peek(8'h20);
        n_chk++; if (rd !== 32'hFF) begin n_fail++; $display("FAIL cnt_saturate: got %h expected ff", rd); end
        wr(8'h20, 32'h0);
        n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL cnt_clear: got %h expected 0", rd); end
    endtask
`endif

    task automatic test_random();
        logic [31:0] a;
        rst = 1'b0; tick(); rst = 1'b1;
        for (int k = 0; k < 400; k++) begin
            irq_in = 4'($urandom);
            rst = ($urandom_range(0, 63) != 0);
            we = 1'($urandom_range(0, 1));
            a = BASE + 32'($urandom_range(0, 15) * 4);
            addr = ($urandom_range(0, 9) == 0) ? a + 32'h40 : a;
            wd = $urandom;
            tick();
            we = 1'b0;
            n_chk++; if (int_out !== (m_pend & m_mask)) begin n_fail++; $display("FAIL rand_int_out @%0d: got %h expected %h", k, int_out, m_pend & m_mask); end
            n_chk++; if (rd !== exp_rd(addr)) begin n_fail++; $display("FAIL rand_rd @%0d addr %h: got %h expected %h", k, addr, rd, exp_rd(addr)); end
            peek(8'($urandom_range(0, 15) * 4));
            n_chk++; if (rd !== exp_rd(addr)) begin n_fail++; $display("FAIL rand_peek @%0d addr %h: got %h expected %h", k, addr, rd, exp_rd(addr)); end
        end
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_edge();
        test_level();
        test_polarity();
        test_force();
        test_decode();
`ifdef IRQ_CTRL_COUNT_EN
        test_count();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
Memory-mapped interrupt controller placed upstream of the mips core. It synchronises external asynchronous interrupt lines and applies per-source polarity, edge/level mode and masking. Its output drives the core's INT[3:0] input. It sits on the data-memory bus beside data memory; the top level muxes its read data into rd_dm whenever hit=1.

Parameters:
NUM_SRC, 4, number of interrupt sources (1..8); bit i of every register maps to source i
BASE_ADDR, 32'h0000_0800, register window base, 64-byte aligned

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-low reset; rst=0 at a rising clk edge resets all state
irq_in  input  NUM_SRC  external asynchronous interrupt lines
we  input  1  bus write strobe (dmem_we)
addr  input  32  bus byte address (dmem_addr)
wd  input  32  bus write data (dmem_out)
rd  output  32  bus read data, combinational
hit  output  1  combinational; 1 when addr[31:6]==BASE_ADDR[31:6]
int_out  output  NUM_SRC  interrupt request to core, equals PEND & MASK (combinational from registers)

Behaviour:
- Register offset is addr[5:2]. A write is accepted only when hit & we. Only bits [NUM_SRC-1:0] are used; other bits read 0 and are ignored on write.
- 0x00 RAW (RO): synchronised, polarity-adjusted line state s[i] = ff2[i] ^ POL[i].
- 0x04 PEND (R/W1C): writing 1 clears the bit, writing 0 has no effect.
- 0x08 MASK (RW).
- 0x0C MODE (RW): 1 = rising-edge, 0 = level.
- 0x10 POL (RW): 1 = active-low.
- 0x14 CLAIM (RO): bit31 = |(PEND&MASK); bits[2:0] = lowest index i with PEND[i]&MASK[i]. Reads 0 when nothing is pending.
- 0x18 FORCE (WO, reads 0): writing 1 sets PEND[i] at that edge.
- Any other offset in the window reads 0; writes to it are ignored.
- Reads are zero-latency: rd is a combinational function of addr and the current registers. rd=0 when hit=0.
- Synchroniser: 2 flops per line (ff1, ff2), plus a prev flop holding the last s[i] for edge detection.
- Set condition per cycle:
  - edge mode: s[i] & ~prev[i]
  - level mode: s[i]
  - FORCE write bit i
- PEND update order at each edge: set wins over a simultaneous W1C clear.
  - Consequence: in level mode, a W1C while the line is still active leaves PEND=1.
- Latency: irq_in toggles active (setup met before edge 1) -> PEND set at edge 3 -> int_out high after edge 3 if MASK=1.
- A POL write loads prev[i] with the new s[i] value in the same cycle, so a polarity change never creates a spurious edge. A MODE write has no side effect on PEND.
- Masking does not block pending: a masked source still sets PEND; unmasking later raises int_out immediately.
- Reset (rst=0): ff1, ff2, prev, PEND, MASK, MODE and POL all go to 0.
  - int_out=0 from the edge where reset is sampled.
  - rd and hit stay combinational.
  - Reset mid-operation discards pending interrupts.
  - The first cycle after reset cannot generate an edge, because prev is reset to the polarity-adjusted idle value 0 and POL=0.

Optional Feature:
IRQ_CTRL_COUNT_EN
- When defined: per-source 8-bit saturating event counter CNT[i] at offset 0x20+4*i (RO in bits[7:0]).
  - Increments on each cycle where the set condition holds and PEND[i] was 0 beforehand, i.e. counts 0->1 transitions of PEND.
  - Saturates at 8'hFF.
  - Any write to a CNT offset clears that counter; a clear in the same cycle as an increment leaves the counter at 0.
  - Reset clears all counters.
- When undefined: offsets 0x20-0x3C read 0, writes are ignored, and no counter logic is instantiated.

Test Plan:
- Reset check: rst=0 for 2 cycles, irq_in=4'b1111 -> int_out=0, PEND=0 and CLAIM=0 throughout reset. After release with MODE=0 and MASK=0, PEND reaches 4'b1111 at the 3rd edge and int_out stays 0.
- Edge latency and W1C: MODE=4'hF, MASK=4'h4, then pulse irq_in[2] high for 1 cycle (setup met) -> PEND=4'h4 at edge 3, int_out=4'h4, CLAIM=32'h8000_0002. Write 0x04 with 4'h4 -> PEND=0 and int_out=0 next cycle, and no re-trigger.
- Level plus simultaneous set/clear: MODE=0, MASK=1, irq_in[0] held high; write PEND with 1 -> PEND[0] remains 1. Drop irq_in[0] for 3 cycles, then write PEND with 1 -> PEND[0]=0.
- Polarity: POL=4'h2, MODE=4'h2, irq_in[1] held 1 and then driven to 0 -> PEND[1]=1 three edges after the fall. Writing POL=0 while irq_in[1]=1 -> no new PEND.
- Priority and FORCE: write FORCE=4'hA with MASK=4'hF -> CLAIM=32'h8000_0001. Clear bit 1 -> CLAIM=32'h8000_0003.
- Address decode: a write with addr=BASE_ADDR+0x40 -> hit=0, no register change, rd=0.
  - With IRQ_CTRL_COUNT_EN: 300 edge events on source 0 -> CNT0=8'hFF; writing 0x20 -> CNT0=0.
